// File: rtl/tournament_predictor_p_if.sv
// ---------------------------------------------------------------------------
// tournament_predictor_p_if
// Groups the query and branch-training signals of the tournament predictor.
//   master : drives queries (q_valid, q_address) and resolved branches
//            (branch_record_en, branch_address, branch_take, branch_hist,
//            branch_mispredict); receives q_take / q_hist.
//   slave  : the predictor itself; returns q_take (combinational prediction)
//            and q_hist (speculative global history used for the query).
// ---------------------------------------------------------------------------
interface tournament_predictor_p_if #(
  parameter int ADDR_W = 17,
  parameter int HIST_W = 10
);
  logic              q_valid;
  logic [ADDR_W-1:0] q_address;
  logic              q_take;
  logic [HIST_W-1:0] q_hist;

  logic              branch_record_en;
  logic [ADDR_W-1:0] branch_address;
  logic              branch_take;
  logic [HIST_W-1:0] branch_hist;
  logic              branch_mispredict;

  modport master (
    output q_valid, q_address,
    output branch_record_en, branch_address, branch_take, branch_hist, branch_mispredict,
    input  q_take, q_hist
  );

  modport slave (
    input  q_valid, q_address,
    input  branch_record_en, branch_address, branch_take, branch_hist, branch_mispredict,
    output q_take, q_hist
  );
endinterface

// File: rtl/tournament_predictor_p.sv
// ---------------------------------------------------------------------------
// tournament_predictor_p
// Tournament branch predictor: a global (gshare or history-indexed) counter
// table and a local (address-indexed) counter table, arbitrated per address
// by a selector table. Tables are cleared by an INIT sweep after reset.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   hci_rdy     : stall gate; low freezes history and training updates
//   ready       : high once the table initialisation sweep is complete
//   bus (slave) : query in / prediction out, resolved-branch training in
// ---------------------------------------------------------------------------
module tournament_predictor_p #(
  parameter int ADDR_W = 17,
  parameter int IDX_W  = 10,
  parameter int HIST_W = 10,
  parameter int CTR_W  = 2,
  parameter int GSHARE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hci_rdy,
  output logic ready,
  tournament_predictor_p_if.slave bus
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  // 2^(CTR_W-1)-1: weakly favours the global table after init.
  localparam logic [CTR_W-1:0] SEL_INIT = CTR_MAX >> 1;
  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            state;
  logic [IDX_W-1:0]  init_ptr;
  logic [HIST_W-1:0] spec_ghr;

  logic [CTR_W-1:0] global_ctr [ENTRIES];
  logic [CTR_W-1:0] local_ctr  [ENTRIES];
  logic [CTR_W-1:0] selector   [ENTRIES];

  logic [IDX_W-1:0] q_lidx, q_gidx, b_lidx, b_gidx;
  logic             pred_take;
  logic [CTR_W-1:0] b_local, b_global, b_sel;
  logic [CTR_W-1:0] local_next, global_next, sel_next;
  logic             local_ok, global_ok;
  logic             train_en;
  logic             unused_addr_bits;

  function automatic logic [CTR_W-1:0] ctr_step(input logic [CTR_W-1:0] c,
                                                 input logic up);
    if (up) return (c == CTR_MAX) ? c : c + 1'b1;
    else    return (c == '0)      ? c : c - 1'b1;
  endfunction

  function automatic logic [IDX_W-1:0] make_gidx(input logic [IDX_W-1:0] lidx,
                                                  input logic [HIST_W-1:0] hist);
    if (GSHARE != 0) return lidx ^ IDX_W'(hist);
    else             return IDX_W'(hist);
  endfunction

  // Address bits above the index only identify the branch to the caller.
  assign unused_addr_bits = ^{bus.q_address[ADDR_W-1:IDX_W],
                              bus.branch_address[ADDR_W-1:IDX_W]};

  // Query lookup reads the arrays asynchronously, so a same-cycle training
  // write is not yet visible and the query sees pre-update values.
  always_comb begin
    q_lidx    = bus.q_address[IDX_W-1:0];
    q_gidx    = make_gidx(q_lidx, spec_ghr);
    pred_take = selector[q_lidx][CTR_W-1] ? local_ctr[q_lidx][CTR_W-1]
                                          : global_ctr[q_gidx][CTR_W-1];
  end

  assign bus.q_take = ready & pred_take;
  assign bus.q_hist = spec_ghr;

  assign train_en = ready & hci_rdy & bus.branch_record_en;

  // Training uses the history captured at prediction time, not spec_ghr.
  // Selector movement is judged on the counters before this update.
  always_comb begin
    b_lidx      = bus.branch_address[IDX_W-1:0];
    b_gidx      = make_gidx(b_lidx, bus.branch_hist);
    b_local     = local_ctr[b_lidx];
    b_global    = global_ctr[b_gidx];
    b_sel       = selector[b_lidx];
    local_ok    = (b_local[CTR_W-1]  == bus.branch_take);
    global_ok   = (b_global[CTR_W-1] == bus.branch_take);
    local_next  = ctr_step(b_local,  bus.branch_take);
    global_next = ctr_step(b_global, bus.branch_take);
    sel_next    = b_sel;
    if (global_ok && !local_ok)      sel_next = ctr_step(b_sel, 1'b0);
    else if (local_ok && !global_ok) sel_next = ctr_step(b_sel, 1'b1);
  end

  // Table storage has no reset; the INIT sweep rewrites every entry.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      global_ctr[init_ptr] <= '0;
      local_ctr[init_ptr]  <= '0;
      selector[init_ptr]   <= SEL_INIT;
    end else if (train_en) begin
      global_ctr[b_gidx] <= global_next;
      local_ctr[b_lidx]  <= local_next;
      selector[b_lidx]   <= sel_next;
    end
  end

  // Control FSM. A mispredict restore wins over a same-cycle query shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      init_ptr <= '0;
      spec_ghr <= '0;
      ready    <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          init_ptr <= init_ptr + 1'b1;
          if (init_ptr == LAST_IDX) begin
            state <= ST_RUN;
            ready <= 1'b1;
          end
        end
        ST_RUN: begin
          if (hci_rdy) begin
            if (bus.branch_record_en && bus.branch_mispredict)
              spec_ghr <= {bus.branch_hist[HIST_W-2:0], bus.branch_take};
            else if (bus.q_valid)
              spec_ghr <= {spec_ghr[HIST_W-2:0], pred_take};
          end
        end
        default: begin
          state <= ST_INIT;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tournament_predictor_p.sv
// ---------------------------------------------------------------------------
// tb_tournament_predictor_p
// Scoreboard bench for tournament_predictor_p at default parameters. The
// driver issues one cycle of stimulus at a time, pushes the expected query
// response computed by an arithmetic reference model, and a negedge monitor
// pops and compares whenever a query is presented.
// ---------------------------------------------------------------------------
module tb_tournament_predictor_p;

  localparam int ENTRIES = 1024;
  localparam int CMAX    = 3;
  localparam int SELINIT = 1;
  localparam int HALF    = 2;

  logic clk;
  logic rst_n;
  logic hci_rdy;
  logic ready;

  tournament_predictor_p_if #(.ADDR_W(17), .HIST_W(10)) bus ();

  tournament_predictor_p dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .hci_rdy (hci_rdy),
    .ready   (ready),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       take;
    logic [9:0] hist;
    logic       rdy;
  } exp_t;

  exp_t sb[$];
  int   n_compared = 0;
  int   n_mismatch = 0;

  // Reference model state
  int m_glb [ENTRIES];
  int m_loc [ENTRIES];
  int m_sel [ENTRIES];
  int m_ghr;
  bit m_ready;
  int m_init_cnt;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatch++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_glb[i] = 0;
      m_loc[i] = 0;
      m_sel[i] = SELINIT;
    end
    m_ghr      = 0;
    m_ready    = 0;
    m_init_cnt = 0;
  endfunction

  function automatic bit modelPredict(input int addr);
    int l, g;
    l = addr % ENTRIES;
    g = (l ^ m_ghr) % ENTRIES;
    if (m_sel[l] >= HALF) return m_loc[l] >= HALF;
    else                  return m_glb[g] >= HALF;
  endfunction

  function automatic void modelTrain(input int addr, input bit taken, input int hist);
    int l, g;
    bit lok, gok;
    l   = addr % ENTRIES;
    g   = (l ^ hist) % ENTRIES;
    lok = ((m_loc[l] >= HALF) == taken);
    gok = ((m_glb[g] >= HALF) == taken);
    if (gok && !lok && m_sel[l] > 0)         m_sel[l] = m_sel[l] - 1;
    else if (lok && !gok && m_sel[l] < CMAX) m_sel[l] = m_sel[l] + 1;
    if (taken) begin
      if (m_loc[l] < CMAX) m_loc[l] = m_loc[l] + 1;
      if (m_glb[g] < CMAX) m_glb[g] = m_glb[g] + 1;
    end else begin
      if (m_loc[l] > 0) m_loc[l] = m_loc[l] - 1;
      if (m_glb[g] > 0) m_glb[g] = m_glb[g] - 1;
    end
  endfunction

  // Drives one cycle (called at posedge+1), records the expectation,
  // advances the model across the coming edge, returns at posedge+1.
  task automatic applyStimulus(input bit hr, input bit qv, input int qa,
                               input bit be, input int ba, input bit bt,
                               input int bh, input bit bm);
    exp_t e;
    bit   pred;
    logic [16:0] qa_v, ba_v;
    logic [9:0]  bh_v;
    qa_v = qa[16:0];
    ba_v = ba[16:0];
    bh_v = bh[9:0];
    hci_rdy               = hr;
    bus.q_valid           = qv;
    bus.q_address         = qa_v;
    bus.branch_record_en  = be;
    bus.branch_address    = ba_v;
    bus.branch_take       = bt;
    bus.branch_hist       = bh_v;
    bus.branch_mispredict = bm;
    pred   = m_ready ? modelPredict(int'(qa_v)) : 1'b0;
    e.take = pred;
    e.hist = m_ghr[9:0];
    e.rdy  = m_ready;
    if (qv) sb.push_back(e);
    if (!m_ready) begin
      m_init_cnt++;
      if (m_init_cnt == ENTRIES) m_ready = 1;
    end else if (hr) begin
      if (be) modelTrain(int'(ba_v), bt, int'(bh_v));
      if (be && bm)  m_ghr = (int'(bh_v) * 2 + int'(bt)) % ENTRIES;
      else if (qv)   m_ghr = (m_ghr * 2 + int'(pred)) % ENTRIES;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic randomCycle();
    int qa, ba, bh;
    qa = int'($urandom & 32'h1FFFF);
    if ($urandom_range(0, 3) != 0) qa = (qa & 32'h1FC00) | int'($urandom_range(0, 15));
    ba = int'($urandom & 32'h1FFFF);
    if ($urandom_range(0, 3) != 0) ba = (ba & 32'h1FC00) | int'($urandom_range(0, 15));
    bh = ($urandom_range(0, 1) == 0) ? m_ghr : int'($urandom_range(0, 1023));
    applyStimulus($urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1, qa,
                  $urandom_range(0, 9) < 4, ba, $urandom_range(0, 1) == 1, bh,
                  $urandom_range(0, 3) == 0);
  endtask

  task automatic idleInputs();
    hci_rdy               = 1'b1;
    bus.q_valid           = 1'b0;
    bus.q_address         = '0;
    bus.branch_record_en  = 1'b0;
    bus.branch_address    = '0;
    bus.branch_take       = 1'b0;
    bus.branch_hist       = '0;
    bus.branch_mispredict = 1'b0;
  endtask

  // Constant-expectation peek of the combinational prediction (no consume).
  task automatic peekTake(input int addr, input bit expected, input string name);
    logic [16:0] a;
    a = addr[16:0];
    idleInputs();
    bus.q_address = a;
    #1;
    checkOutput(name, bus.q_take, expected);
  endtask

  task automatic runInit();
    for (int i = 0; i < ENTRIES; i++) begin
      if (i == ENTRIES - 1) checkOutput("init_ready_low", ready, 1'b0);
      randomCycle();
    end
    checkOutput("init_ready_high", ready, 1'b1);
  endtask

  task automatic train(input int addr, input bit taken, input int hist, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 1, addr, taken, hist, 0);
  endtask

  task automatic query(input int addr);
    applyStimulus(1, 1, addr, 0, 0, 0, 0, 0);
  endtask

  // Monitor: pops one expectation per presented query.
  always @(negedge clk) begin
    if (rst_n && bus.q_valid) begin
      if (sb.size() == 0) begin
        n_compared++;
        n_mismatch++;
        $display("[TB] FAIL sb_underflow: actual query with no expectation");
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("q_take", bus.q_take, e.take);
        checkOutput("q_hist", bus.q_hist, e.hist);
        checkOutput("ready",  ready,      e.rdy);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    idleInputs();
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ready", ready, 1'b0);
    checkOutput("reset_hist",  bus.q_hist, 10'h000);
    rst_n = 1'b1;
    runInit();

    // Two taken trainings, history stays 0, prediction taken
    train(32'h40, 1, 0, 2);
    checkOutput("train_keeps_ghr", bus.q_hist, 10'h000);
    peekTake(32'h40, 1'b1, "two_taken_take");
    query(32'h40);
    applyStimulus(1, 0, 0, 1, 32'h200, 0, 0, 1);
    checkOutput("restore_zero", bus.q_hist, 10'h000);

    // Five taken then one not-taken
    train(32'h40, 1, 0, 5);
    train(32'h40, 0, 0, 1);
    peekTake(32'h40, 1'b1, "five_one_take");

    // Counter saturation at both ends
    train(32'h80, 0, 0, 1);
    peekTake(32'h80, 1'b0, "sat_low");
    train(32'h100, 1, 0, 4);
    train(32'h100, 0, 0, 2);
    peekTake(32'h100, 1'b0, "sat_high");

    // Three taken queries then mispredict restore
    checkOutput("ghr_before_q", bus.q_hist, 10'h000);
    query(32'h40);
    query(32'h41);
    query(32'h43);
    checkOutput("ghr_three_taken", bus.q_hist, 10'h007);
    applyStimulus(1, 0, 0, 1, 32'h300, 0, 32'h001, 1);
    checkOutput("ghr_restore", bus.q_hist, 10'h002);

    // Query and mispredict in the same cycle; then stalled cycles
    applyStimulus(1, 1, 32'h40, 1, 32'h300, 1, 32'h005, 1);
    checkOutput("restore_priority", bus.q_hist, 10'h00B);
    for (int i = 0; i < 6; i++)
      applyStimulus(0, 1, int'($urandom_range(0, 255)), 1, int'($urandom_range(0, 255)),
                    $urandom_range(0, 1) == 1, int'($urandom_range(0, 1023)), 1);
    checkOutput("stall_hist", bus.q_hist, 10'h00B);

    for (int i = 0; i < 3000; i++) randomCycle();

    // Asynchronous reset in the middle of RUN
    query(32'h40);
    applyStimulus(1, 0, 0, 1, 32'h300, 1, 32'h155, 1);
    checkOutput("pre_reset_ready", ready, 1'b1);
    checkOutput("pre_reset_hist",  bus.q_hist, 10'h2AB);
    idleInputs();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_ready", ready, 1'b0);
    checkOutput("async_hist",  bus.q_hist, 10'h000);
    checkOutput("async_take",  bus.q_take, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    modelReset();
    runInit();
    for (int i = 0; i < 300; i++) randomCycle();

    idleInputs();
    @(posedge clk);
    #1;
    checkOutput("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule

// File: doc/tournament_predictor_p.md
TOURNAMENT_PREDICTOR_P -- requirements
Module: tournament_predictor_p

Interface
REQ-001 SHALL have parameter ADDR_W, default 17, meaning branch/query address width.
REQ-002 SHALL have parameter IDX_W, default 10, meaning table index width; each table holds 2^IDX_W entries.
REQ-003 SHALL have parameter HIST_W, default 10, meaning global history width; legal range 2..IDX_W.
REQ-004 SHALL have parameter CTR_W, default 2, meaning saturating counter width for all tables.
REQ-005 SHALL have parameter GSHARE, default 1, meaning global index mode: 1 = address XOR history, 0 = history only.
REQ-006 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-008 SHALL have port hci_rdy, input, 1, meaning stall gate; low freezes query-history and training updates.
REQ-009 SHALL have port q_valid, input, 1, meaning a query is consumed this cycle.
REQ-010 SHALL have port q_address, input, ADDR_W, meaning query branch address.
REQ-011 SHALL have port q_take, output, 1, meaning combinational prediction.
REQ-012 SHALL have port q_hist, output, HIST_W, meaning speculative history used for this query; carried with the branch.
REQ-013 SHALL have port branch_record_en, input, 1, meaning resolved-branch training strobe.
REQ-014 SHALL have port branch_address, input, ADDR_W, meaning resolved branch address.
REQ-015 SHALL have port branch_take, input, 1, meaning resolved direction.
REQ-016 SHALL have port branch_hist, input, HIST_W, meaning q_hist captured when this branch was predicted.
REQ-017 SHALL have port branch_mispredict, input, 1, meaning resolved direction differs from prediction; qualifies branch_record_en.
REQ-018 SHALL have port ready, output, 1, meaning table initialisation complete.

Function
REQ-019 SHALL hold three tables: global_ctr, local_ctr, selector; selector MSB=1 selects local.
REQ-020 SHALL compute lidx = address[IDX_W-1:0]; gidx = lidx XOR zero-extended history when GSHARE=1, else zero-extended history.
REQ-021 SHALL run FSM INIT->RUN: INIT writes entry init_ptr of all tables each cycle (counters 0, selector 2^(CTR_W-1)-1), independent of hci_rdy; after entry 2^IDX_W-1 enter RUN; ready=1 from next edge (2^IDX_W cycles).
REQ-022 SHALL ignore q_valid and branch_record_en while in INIT; q_take=0 and q_hist=spec_ghr while ready=0.
REQ-023 SHALL in RUN drive q_take = selector[lidx] MSB ? local_ctr[lidx] MSB : global_ctr[gidx] MSB, with gidx from spec_ghr; q_hist=spec_ghr.
REQ-024 SHALL on ready & hci_rdy & q_valid (no mispredict) shift spec_ghr <= {spec_ghr[HIST_W-2:0], q_take}.
REQ-025 SHALL on ready & hci_rdy & branch_record_en train at lidx and gidx (gidx from branch_address, branch_hist): both counters +1 if taken, -1 if not, saturating at 2^CTR_W-1 and 0.
REQ-026 SHALL decrement selector (saturating 0) when global MSB correct and local MSB wrong; increment (saturating max) when local correct and global wrong; else unchanged; evaluated on pre-update counters.
REQ-027 SHALL on branch_record_en & branch_mispredict restore spec_ghr <= {branch_hist[HIST_W-2:0], branch_take}.
REQ-028 SHALL give mispredict restore priority over a same-cycle query shift; the query shift is discarded.
REQ-029 SHALL return pre-update table values to a query reading an entry being trained the same cycle.
REQ-030 SHALL leave all state unchanged in RUN when hci_rdy=0.

Reset
REQ-031 SHALL on rst_n low immediately force FSM=INIT, init_ptr=0, spec_ghr=0, ready=0, q_take=0; table contents are rewritten by INIT, not by reset.
REQ-032 SHALL restart full initialisation after reset asserted mid-INIT or mid-RUN.

Verification (defaults)
REQ-033 SHALL pass: release rst_n -> ready=0 for 1024 cycles, rises after; q_take=0 throughout INIT.
REQ-034 SHALL pass: 2 training events addr 0x40, hist 0, taken, no mispredict -> query 0x40 with spec_ghr=0 gives q_take=1; spec_ghr stays 0.
REQ-035 SHALL pass: 5 taken then 1 not-taken at one address -> counters 3 then 2; q_take remains 1.
REQ-036 SHALL pass: 3 queries predicting taken -> spec_ghr=0x007; mispredict with branch_hist=0x001, take=0 -> spec_ghr=0x002.
REQ-037 SHALL pass: q_valid and mispredict same cycle -> spec_ghr equals restore value only; hci_rdy=0 cycles change nothing.
REQ-038 SHALL pass: rst_n low asynchronously mid-RUN -> ready and spec_ghr 0 before next edge; INIT reruns 1024 cycles.
